// File: rtl/fp_addsub_ctrl_if.sv
// Bundle of request, FPU and writeback signals for fp_addsub_ctrl.
// slave = controller side, master = decode / add_sub_fp / writeback side.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid that has been raised is held, with its payload stable,
// until that transfer. ready never depends combinationally on valid.
interface fp_addsub_ctrl_if #(
    parameter int Size = 64
);
    // decode request
    logic            req_valid;
    logic            req_ready;
    logic            req_sub;
    logic            req_single;
    logic [2:0]      req_rm;
    logic [Size-1:0] req_rs1;
    logic [Size-1:0] req_rs2;
    logic [4:0]      req_rd;
    logic [2:0]      frm;
    // add_sub_fp start/done
    logic            fpu_start;
    logic            fpu_sub;
    logic            fpu_single;
    logic [2:0]      fpu_rounding_mode;
    logic [Size-1:0] fpu_operand_a;
    logic [Size-1:0] fpu_operand_b;
    logic            fpu_done;
    logic [Size-1:0] fpu_result;
    logic            fpu_overflow;
    logic            fpu_underflow;
    logic            fpu_inexact;
    logic            fpu_invalid;
    // writeback and fcsr
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [Size-1:0] wb_data;
    logic [4:0]      wb_fflags;
    logic [4:0]      fflags_accrued;
    logic            fflags_clear;
    logic            illegal;

    modport slave (
        input  req_valid, req_sub, req_single, req_rm, req_rs1, req_rs2, req_rd, frm,
        input  fpu_done, fpu_result, fpu_overflow, fpu_underflow, fpu_inexact, fpu_invalid,
        input  wb_ready, fflags_clear,
        output req_ready, fpu_start, fpu_sub, fpu_single, fpu_rounding_mode,
        output fpu_operand_a, fpu_operand_b,
        output wb_valid, wb_rd, wb_data, wb_fflags, fflags_accrued, illegal
    );

    modport master (
        output req_valid, req_sub, req_single, req_rm, req_rs1, req_rs2, req_rd, frm,
        output fpu_done, fpu_result, fpu_overflow, fpu_underflow, fpu_inexact, fpu_invalid,
        output wb_ready, fflags_clear,
        input  req_ready, fpu_start, fpu_sub, fpu_single, fpu_rounding_mode,
        input  fpu_operand_a, fpu_operand_b,
        input  wb_valid, wb_rd, wb_data, wb_fflags, fflags_accrued, illegal
    );
endinterface

// File: rtl/fp_addsub_ctrl.sv
// FADD/FSUB issue and writeback controller around add_sub_fp (FLEN = 64).
// Resolves the rounding mode, unboxes single operands, times out a silent
// unit, NaN-boxes single results and accrues fflags.
// Optional build macro FP_ADDSUB_NAN_BYPASS_EN: NaN operands skip the unit
// and write back the canonical NaN directly.
module fp_addsub_ctrl #(
    parameter int Size          = 64,
    parameter int TimeoutCycles = 64
) (
    input  logic            clk,
    input  logic            reset,
    fp_addsub_ctrl_if.slave bus,
    output logic [1:0]      dbg_state_o
);
    localparam logic [Size-1:0] CanonNanS = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [Size-1:0] CanonNanD = 64'h7FF8_0000_0000_0000;
    localparam int              CntW      = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sub_q, sub_d;
    logic            single_q, single_d;
    logic [2:0]      rm_q, rm_d;
    logic [Size-1:0] opa_q, opa_d;
    logic [Size-1:0] opb_q, opb_d;
    logic [4:0]      rd_q, rd_d;
    logic [Size-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_fflags_q, wb_fflags_d;
    logic [4:0]      accrued_q, accrued_d;
    logic            illegal_q, illegal_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [2:0]      rm_res;
    logic            rm_bad;
    logic [Size-1:0] opa_unbox;
    logic [Size-1:0] opb_unbox;
    logic            wb_hs;

    // Dynamic rm takes fcsr.frm; 101/110/111 have no rounding meaning.
    assign rm_res    = (bus.req_rm == 3'b111) ? bus.frm : bus.req_rm;
    assign rm_bad    = (rm_res == 3'b101) || (rm_res == 3'b110) || (rm_res == 3'b111);
    // An improperly boxed single operand reads as the canonical single NaN.
    assign opa_unbox = (bus.req_single && (bus.req_rs1[63:32] != 32'hFFFF_FFFF)) ? CanonNanS : bus.req_rs1;
    assign opb_unbox = (bus.req_single && (bus.req_rs2[63:32] != 32'hFFFF_FFFF)) ? CanonNanS : bus.req_rs2;
    assign wb_hs     = (state_q == WB) && bus.wb_ready;

`ifdef FP_ADDSUB_NAN_BYPASS_EN
    logic byp_nan;
    logic byp_snan;

    function automatic logic is_nan(input logic [Size-1:0] v, input logic single);
        if (single) return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
    endfunction

    function automatic logic is_snan(input logic [Size-1:0] v, input logic single);
        if (single) return is_nan(v, 1'b1) && !v[22];
        return is_nan(v, 1'b0) && !v[51];
    endfunction

    assign byp_nan  = is_nan(opa_unbox, bus.req_single) || is_nan(opb_unbox, bus.req_single);
    assign byp_snan = is_snan(opa_unbox, bus.req_single) || is_snan(opb_unbox, bus.req_single);
`endif

    // Next-state and datapath capture; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        single_d    = single_q;
        rm_d        = rm_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rd_d        = rd_q;
        wb_data_d   = wb_data_q;
        wb_fflags_d = wb_fflags_q;
        illegal_d   = 1'b0;
        cnt_d       = cnt_q;
        // Clear first, then accrue, so a coinciding handshake still lands.
        accrued_d   = (bus.fflags_clear ? 5'b00000 : accrued_q) | (wb_hs ? wb_fflags_q : 5'b00000);
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (rm_bad) begin
                        illegal_d = 1'b1;
                    end else begin
                        sub_d    = bus.req_sub;
                        single_d = bus.req_single;
                        rm_d     = rm_res;
                        opa_d    = opa_unbox;
                        opb_d    = opb_unbox;
                        rd_d     = bus.req_rd;
                        state_d  = ISSUE;
`ifdef FP_ADDSUB_NAN_BYPASS_EN
                        if (byp_nan) begin
                            wb_data_d   = bus.req_single ? CanonNanS : CanonNanD;
                            wb_fflags_d = {byp_snan, 4'b0000};
                            state_d     = WB;
                        end
`endif
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.fpu_done) begin
                    wb_data_d   = single_q ? {32'hFFFF_FFFF, bus.fpu_result[31:0]} : bus.fpu_result;
                    wb_fflags_d = {bus.fpu_invalid, 1'b0, bus.fpu_overflow, bus.fpu_underflow, bus.fpu_inexact};
                    state_d     = WB;
                end else if (cnt_q == CntLast) begin
                    wb_data_d   = single_q ? CanonNanS : CanonNanD;
                    wb_fflags_d = 5'b10000;
                    state_d     = WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                if (bus.wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight op without writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sub_q       <= 1'b0;
            single_q    <= 1'b0;
            rm_q        <= 3'b000;
            opa_q       <= '0;
            opb_q       <= '0;
            rd_q        <= 5'd0;
            wb_data_q   <= '0;
            wb_fflags_q <= 5'b00000;
            accrued_q   <= 5'b00000;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            single_q    <= single_d;
            rm_q        <= rm_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rd_q        <= rd_d;
            wb_data_q   <= wb_data_d;
            wb_fflags_q <= wb_fflags_d;
            accrued_q   <= accrued_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready         = (state_q == IDLE);
    assign bus.fpu_start         = (state_q == ISSUE);
    assign bus.fpu_sub           = sub_q;
    assign bus.fpu_single        = single_q;
    assign bus.fpu_rounding_mode = rm_q;
    assign bus.fpu_operand_a     = opa_q;
    assign bus.fpu_operand_b     = opb_q;
    assign bus.wb_valid          = (state_q == WB);
    assign bus.wb_rd             = rd_q;
    assign bus.wb_data           = wb_data_q;
    assign bus.wb_fflags         = wb_fflags_q;
    assign bus.fflags_accrued    = accrued_q;
    assign bus.illegal           = illegal_q;
    assign dbg_state_o           = state_q;
endmodule

// File: doc/fp_addsub_ctrl.md
Name: fp_addsub_ctrl

Overview:
- Issue/writeback controller directly upstream and downstream of add_sub_fp in the RV64F FP execute path.
- Accepts FADD/FSUB requests from decode over a valid/ready handshake and resolves the dynamic rounding mode from frm.
- Checks NaN-boxing of single-precision operands, drives the add_sub_fp start/done interface, and NaN-boxes single results.
- Presents results to register writeback and accrues fflags for fcsr.

Parameters:
Size, 64, FLEN; width of operands, results and writeback data.
TimeoutCycles, 64, maximum cycles WAIT holds for fpu_done before forcing a fault result; minimum 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  decode presents a request.
req_ready  out  1  controller accepts a request this cycle.
req_sub  in  1  1 = FSUB, 0 = FADD.
req_single  in  1  1 = single precision (.S), 0 = double (.D).
req_rm  in  3  instruction rm field; 3'b111 = dynamic.
req_rs1, req_rs2  in  Size  raw register operands.
req_rd  in  5  destination register.
frm  in  3  fcsr.frm.
fpu_start  out  1  one-cycle start pulse to add_sub_fp.
fpu_sub  out  1  operation select to add_sub_fp.
fpu_single  out  1  selects the 32-bit unit instance and its done/result.
fpu_rounding_mode  out  3  resolved rounding mode.
fpu_operand_a, fpu_operand_b  out  Size  operands; the 32-bit unit uses bits [31:0].
fpu_done  in  1  unit completion.
fpu_result  in  Size  unit result.
fpu_overflow, fpu_underflow, fpu_inexact, fpu_invalid  in  1  unit exception flags.
wb_valid  out  1  writeback data valid.
wb_ready  in  1  writeback accepts.
wb_rd  out  5  destination register.
wb_data  out  Size  result; NaN-boxed when single.
wb_fflags  out  5  {NV,DZ,OF,UF,NX} for this op; DZ is always 0.
fflags_accrued  out  5  sticky OR of all written-back wb_fflags.
fflags_clear  in  1  clears fflags_accrued.
illegal  out  1  one-cycle pulse on an illegal rounding mode.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0 except req_ready = 1.
  - fflags_accrued = 0; timeout counter = 0.
  - Reset in any state abandons the in-flight op: no wb_valid, no flag accrual.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - req_ready = 1.
  - On req_valid, resolve rm = (req_rm == 3'b111) ? frm : req_rm.
  - If resolved rm is in {101, 110, 111}: assert illegal for exactly the next cycle, consume the request, stay in IDLE.
  - Otherwise latch the request.
  - If req_single and operand[63:32] != 32'hFFFFFFFF, replace that operand with {32'hFFFFFFFF, 32'h7FC00000}.
  - Go to ISSUE.
- ISSUE:
  - fpu_start = 1 for exactly one cycle.
  - fpu_* operand/mode outputs are stable from ISSUE until leaving WAIT.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - Sample fpu_done only here.
  - On fpu_done = 1:
    - Capture wb_data = req_single ? {32'hFFFFFFFF, fpu_result[31:0]} : fpu_result.
    - Capture wb_fflags = {invalid, 0, overflow, underflow, inexact}.
    - Go to WB.
  - If the counter reaches TimeoutCycles without done: wb_data = canonical NaN (single 0xFFFFFFFF7FC00000, double 0x7FF8000000000000), wb_fflags = 5'b10000, go to WB.
- WB:
  - wb_valid = 1; wb_data, wb_rd and wb_fflags are held until wb_ready.
  - On handshake, fflags_accrued |= wb_fflags; go to IDLE.
  - req_ready = 0 in ISSUE, WAIT and WB.
  - No combinational path from req_valid to req_ready.
- fflags_clear:
  - Applied every cycle.
  - If it coincides with a WB handshake: fflags_accrued = wb_fflags (clear, then accrue).
- Latency: request accepted at cycle N, fpu_start at N+1, done at N+1+L, wb_valid at N+2+L.
- Throughput: one op in flight.

Optional Feature:
FP_ADDSUB_NAN_BYPASS_EN:
- Defined: in IDLE, if either operand is NaN after the unbox check, the op skips ISSUE/WAIT.
  - Go directly to WB one cycle after accept with the canonical NaN of the op's precision.
  - NV = 1 if either operand is a signaling NaN (quiet bit 0, mantissa != 0); otherwise flags = 0.
  - fpu_start is never asserted for that op.
- Undefined: all legal ops go through the FPU.

Test Plan:
- Double ADD: rs1 = 0x3FF0000000000000, rs2 = 0x4000000000000000, rm = 000, FPU returns 0x4008000000000000 with no flags, L = 3 -> wb_valid 5 cycles after accept; wb_data = 0x4008000000000000; wb_fflags = 00000.
- Single with bad boxing: rs1 = 0x000000003F800000, req_single = 1 -> fpu_operand_a = 0xFFFFFFFF7FC00000; FPU result 0x7FC00000 -> wb_data = 0xFFFFFFFF7FC00000.
- Dynamic rm with frm = 101 -> illegal pulses for 1 cycle; fpu_start and wb_valid stay 0; next request is accepted the following cycle.
- Backpressure: wb_ready low 5 cycles in WB -> wb_valid and wb_data stable, req_ready = 0; on the 6th cycle, handshake completes and req_ready = 1 the next cycle.
- Flags: two ops returning NX, then OF|NX -> fflags_accrued = 00101; fflags_clear on the next WB with flags 00000 -> 00000.
- Fault cases:
  - fpu_done held low -> after TimeoutCycles, wb_data = 0x7FF8000000000000, wb_fflags = 10000.
  - reset asserted in WAIT -> state IDLE, wb_valid = 0, fflags_accrued = 0 the next cycle.
